// File: rtl/inj_arb_pkg.sv
// inj_arb_pkg
// Shared types and helpers for the injector-port arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE / GRANT)
//   idx_width() : width of an index able to address n sources
package inj_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/inj_port_arbiter_rr_picker.sv
// rr_picker
// Combinational round-robin pick: first requester at or after ptr_i,
// scanning upward and wrapping modulo N_SRC.
// Ports:
//   req_i   in  N_SRC : request vector
//   ptr_i   in  IW    : scan start index (always < N_SRC)
//   valid_o out 1     : at least one request present
//   idx_o   out IW    : winning index (0 when no request)
module rr_picker
    import inj_arb_pkg::*;
#(
    parameter int  N_SRC = 2,
    localparam int IW    = idx_width(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic             valid_o,
    output logic [IW-1:0]    idx_o
);

    logic [2*N_SRC-1:0] req_dbl;
    logic [N_SRC-1:0]   req_rot;
    logic [IW:0]        sum;
    logic               found;

    // Rotating a doubled copy puts the request at ptr_i into bit 0, so a
    // plain lowest-bit-first scan gives the round-robin order.
    assign req_dbl = {req_i, req_i};
    assign req_rot = N_SRC'(req_dbl >> ptr_i);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        found   = 1'b0;
        sum     = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_i} + (IW+1)'(i);
                if (sum >= (IW+1)'(N_SRC)) begin
                    sum = sum - (IW+1)'(N_SRC);
                end
                idx_o = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/inj_port_arbiter.sv
// inj_port_arbiter
// Packet-atomic round-robin arbiter sharing one router local input port
// among N_SRC flit sources. The grant is held until the owner's eop flit
// transfers (tx_o & credit_i); data/credit paths are combinational.
// Optional watchdog: define INJ_ARB_WATCHDOG_EN to revoke a grant after
// TIMEOUT consecutive stalled cycles and flag it in timeout_o/timeout_src_o.
// Ports:
//   clk_i, rst_i           : clock, synchronous active-high reset
//   tx_i/eop_i/data_i      : per-source flit valid, end-of-packet, flit
//   credit_o               : per-source credit (only owner sees credit_i)
//   tx_o/data_o, credit_i  : router-side port
//   grant_o                : one-hot owner, zero when idle
//   timeout_o, timeout_src_o : sticky watchdog flag and offending source
//
// state | meaning
// IDLE  | no owner; pick next requester from ptr
// GRANT | owner g_q holds the port until its eop transfer
module inj_port_arbiter
    import inj_arb_pkg::*;
#(
    parameter int  N_SRC     = 2,
    parameter int  FLIT_SIZE = 32,
    parameter int  TIMEOUT   = 1024,
    localparam int IW        = idx_width(N_SRC)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_SRC-1:0]           tx_i,
    input  logic [N_SRC-1:0]           eop_i,
    input  logic [N_SRC*FLIT_SIZE-1:0] data_i,
    output logic [N_SRC-1:0]           credit_o,
    output logic                       tx_o,
    input  logic                       credit_i,
    output logic [FLIT_SIZE-1:0]       data_o,
    output logic [N_SRC-1:0]           grant_o,
    output logic                       timeout_o,
    output logic [IW-1:0]              timeout_src_o
);

    if (N_SRC < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("inj_port_arbiter: N_SRC must be >= 2 and TIMEOUT >= 1");
    end

    arb_state_t           state_q, state_d;
    logic [IW-1:0]        g_q, g_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [N_SRC-1:0]     grant_q, grant_d;
    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic [IW-1:0]        g_next;
    logic                 xfer;
    logic                 eop_xfer;
    logic [FLIT_SIZE-1:0] src_data [N_SRC];

    for (genvar k = 0; k < N_SRC; k++) begin : g_unpack
        assign src_data[k] = data_i[k*FLIT_SIZE +: FLIT_SIZE];
    end

    rr_picker #(
        .N_SRC (N_SRC)
    ) u_picker (
        .req_i   (tx_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        tx_o     = 1'b0;
        data_o   = '0;
        credit_o = '0;
        if (state_q == GRANT) begin
            tx_o           = tx_i[g_q];
            data_o         = src_data[g_q];
            credit_o[g_q]  = credit_i;
        end
    end

    // tx_o is already 0 in IDLE, so xfer implies GRANT.
    assign xfer     = tx_o & credit_i;
    assign eop_xfer = xfer & eop_i[g_q];
    assign g_next   = (g_q == IW'(N_SRC-1)) ? '0 : g_q + 1'b1;

`ifdef INJ_ARB_WATCHDOG_EN
    localparam int SW = $clog2(TIMEOUT+1);

    logic [SW-1:0] stall_q, stall_d;
    logic          timeout_q, timeout_d;
    logic [IW-1:0] tsrc_q, tsrc_d;
    logic          stall_hit;

    // Fires on the edge where the stall count would reach TIMEOUT.
    assign stall_hit = (state_q == GRANT) && !xfer && (stall_q == SW'(TIMEOUT-1));
`endif

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
`ifdef INJ_ARB_WATCHDOG_EN
        stall_d   = '0;
        timeout_d = timeout_q;
        tsrc_d    = tsrc_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d           = GRANT;
                    g_d               = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                end
            end
            GRANT: begin
                if (eop_xfer) begin
                    state_d = IDLE;
                    ptr_d   = g_next;
                    grant_d = '0;
                end
`ifdef INJ_ARB_WATCHDOG_EN
                else if (stall_hit) begin
                    state_d   = IDLE;
                    ptr_d     = g_next;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    tsrc_d    = g_q;
                end else if (!xfer) begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            g_q       <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
`ifdef INJ_ARB_WATCHDOG_EN
            stall_q   <= '0;
            timeout_q <= 1'b0;
            tsrc_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
`ifdef INJ_ARB_WATCHDOG_EN
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
            tsrc_q    <= tsrc_d;
`endif
        end
    end

    assign grant_o = grant_q;

`ifdef INJ_ARB_WATCHDOG_EN
    assign timeout_o     = timeout_q;
    assign timeout_src_o = tsrc_q;
`else
    assign timeout_o     = 1'b0;
    assign timeout_src_o = '0;
`endif

endmodule
